// File: rtl/register_file_pipelined.sv
// register_file_pipelined: scoreboarded register file between decode and writeback.
//   Two combinational read ports (data + pending), one write port with optional
//   same-cycle bypass, optional hardwired-zero entry 0, per-entry pending bits,
//   and a one-entry-per-cycle clear sweep that holds off writes and reserves.
// Ports:
//   clock, reset_n                     clock, async active-low reset
//   write/writeAddress/writeData       write request; writeReady = !busy
//   reserve/reserveAddress             set the pending bit of an entry
//   clear, busy                        start a clear sweep / sweep in progress
//   address1/2 -> data1/2, pending1/2  combinational read ports
module register_file_pipelined #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [WIDTH-1:0]      writeData,
  output logic                  writeReady,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] reserveAddress,
  input  logic                  clear,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [ADDR_WIDTH-1:0] address2,
  output logic [WIDTH-1:0]      data1,
  output logic [WIDTH-1:0]      data2,
  output logic                  pending1,
  output logic                  pending2
);

  localparam int unsigned          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]  DEPTH_A  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_sb;

  logic w_wr_acc;
  logic w_rs_acc;

  // Address maps to a real, writable entry (in range and not the hardwired zero).
  function automatic logic f_valid(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_A) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes held during reset are never stored, so they must not be forwarded either.
  assign w_wr_acc   = reset_n && write && !r_busy && f_valid(writeAddress);
  assign w_rs_acc   = reserve && !r_busy && f_valid(reserveAddress);
  assign busy       = r_busy;
  assign writeReady = !r_busy;

  // Read port 1
  always_comb begin
    data1    = '0;
    pending1 = 1'b0;
    if (f_valid(address1)) begin
      data1    = r_mem[IDX_W'(address1)];
      pending1 = r_sb[IDX_W'(address1)];
      if ((BYPASS != 0) && w_wr_acc && (writeAddress == address1)) data1 = writeData;
    end
  end

  // Read port 2
  always_comb begin
    data2    = '0;
    pending2 = 1'b0;
    if (f_valid(address2)) begin
      data2    = r_mem[IDX_W'(address2)];
      pending2 = r_sb[IDX_W'(address2)];
      if ((BYPASS != 0) && w_wr_acc && (writeAddress == address2)) data2 = writeData;
    end
  end

  // Array, scoreboard and clear sequencer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_sb    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // Reserve is applied after the write so a same-entry reserve wins.
      if (w_wr_acc) begin
        r_mem[IDX_W'(writeAddress)] <= writeData;
        r_sb[IDX_W'(writeAddress)]  <= 1'b0;
      end
      if (w_rs_acc) r_sb[IDX_W'(reserveAddress)] <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_mem[r_idx] <= '0;
          r_sb[r_idx]  <= 1'b0;
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_pipelined.sv
// Bench for register_file_pipelined. Three instances share the inputs:
//   [0] defaults (BYPASS=1, ZERO_REG=0), [1] BYPASS=0, [2] ZERO_REG=1.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_register_file_pipelined;

  logic        clock;
  logic        reset_n;
  logic        write;
  logic [3:0]  writeAddress;
  logic [15:0] writeData;
  logic        reserve;
  logic [3:0]  reserveAddress;
  logic        clear;
  logic [3:0]  address1;
  logic [3:0]  address2;

  logic [15:0] data1 [3];
  logic [15:0] data2 [3];
  logic        pending1 [3];
  logic        pending2 [3];
  logic        busy [3];
  logic        wready [3];

  int checks;
  int errors;

  register_file_pipelined #(.WIDTH(16), .DEPTH(8), .ADDR_WIDTH(4), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .write(write), .writeAddress(writeAddress),
    .writeData(writeData), .writeReady(wready[0]), .reserve(reserve),
    .reserveAddress(reserveAddress), .clear(clear), .busy(busy[0]),
    .address1(address1), .address2(address2), .data1(data1[0]), .data2(data2[0]),
    .pending1(pending1[0]), .pending2(pending2[0]));

  register_file_pipelined #(.WIDTH(16), .DEPTH(8), .ADDR_WIDTH(4), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .write(write), .writeAddress(writeAddress),
    .writeData(writeData), .writeReady(wready[1]), .reserve(reserve),
    .reserveAddress(reserveAddress), .clear(clear), .busy(busy[1]),
    .address1(address1), .address2(address2), .data1(data1[1]), .data2(data2[1]),
    .pending1(pending1[1]), .pending2(pending2[1]));

  register_file_pipelined #(.WIDTH(16), .DEPTH(8), .ADDR_WIDTH(4), .ZERO_REG(1), .BYPASS(1)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .write(write), .writeAddress(writeAddress),
    .writeData(writeData), .writeReady(wready[2]), .reserve(reserve),
    .reserveAddress(reserveAddress), .clear(clear), .busy(busy[2]),
    .address1(address1), .address2(address2), .data1(data1[2]), .data2(data2[2]),
    .pending1(pending1[2]), .pending2(pending2[2]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic idle_inputs();
    write = 1'b0; writeAddress = '0; writeData = '0;
    reserve = 1'b0; reserveAddress = '0; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    write = 1'b1; writeAddress = 4'd3; writeData = 16'hABCD;
    reserve = 1'b1; reserveAddress = 4'd3; clear = 1'b1;
    address1 = 4'd3; address2 = 4'd3;
    #2;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (data1[j] !== 16'h0000 || data2[j] !== 16'h0000) begin
        errors++; $display("FAIL reset_data dut%0d got %h/%h exp 0000", j, data1[j], data2[j]);
      end
      checks++;
      if (busy[j] !== 1'b0 || wready[j] !== 1'b1 || pending1[j] !== 1'b0) begin
        errors++; $display("FAIL reset_ctrl dut%0d busy %b ready %b pend %b exp 0 1 0", j, busy[j], wready[j], pending1[j]);
      end
    end
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clock);
    write = 1'b1; writeAddress = 4'd3; writeData = 16'h1234;
    @(negedge clock);
    idle_inputs(); address1 = 4'd3;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (data1[j] !== 16'h1234) begin
        errors++; $display("FAIL write_read dut%0d got %h exp 1234", j, data1[j]);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    write = 1'b1; writeAddress = 4'd5; writeData = 16'hBEEF;
    address1 = 4'd5; address2 = 4'd5;
    #1;
    checks++;
    if (data1[0] !== 16'hBEEF || data2[0] !== 16'hBEEF) begin
      errors++; $display("FAIL bypass_same_cycle got %h/%h exp beef", data1[0], data2[0]);
    end
    checks++;
    if (data1[1] !== 16'h0000) begin
      errors++; $display("FAIL nobypass_old got %h exp 0000", data1[1]);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (data1[1] !== 16'hBEEF || data2[1] !== 16'hBEEF) begin
      errors++; $display("FAIL nobypass_next got %h/%h exp beef", data1[1], data2[1]);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clock);
    reserve = 1'b1; reserveAddress = 4'd2; address1 = 4'd2; address2 = 4'd2;
    #1;
    checks++;
    if (pending1[0] !== 1'b0) begin
      errors++; $display("FAIL pend_not_bypassed got %b exp 0", pending1[0]);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (pending1[0] !== 1'b1 || pending2[0] !== 1'b1) begin
      errors++; $display("FAIL pend_set got %b/%b exp 1/1", pending1[0], pending2[0]);
    end
    @(negedge clock);
    write = 1'b1; writeAddress = 4'd2; writeData = 16'h7777;
    reserve = 1'b1; reserveAddress = 4'd2;
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (pending1[0] !== 1'b1 || data1[0] !== 16'h7777) begin
      errors++; $display("FAIL wr_rsv_same got pend %b data %h exp 1 7777", pending1[0], data1[0]);
    end
    @(negedge clock);
    write = 1'b1; writeAddress = 4'd2; writeData = 16'h0042;
    #1;
    checks++;
    if (pending1[0] !== 1'b1) begin
      errors++; $display("FAIL pend_before_edge got %b exp 1", pending1[0]);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (pending1[0] !== 1'b0 || data1[0] !== 16'h0042) begin
      errors++; $display("FAIL pend_cleared got pend %b data %h exp 0 0042", pending1[0], data1[0]);
    end
  endtask

  task automatic test_zero_reg_range();
    @(negedge clock);
    write = 1'b1; writeAddress = 4'd0; writeData = 16'hFFFF;
    reserve = 1'b1; reserveAddress = 4'd0; address1 = 4'd0;
    #1;
    checks++;
    if (data1[2] !== 16'h0000) begin
      errors++; $display("FAIL zero_reg_bypass got %h exp 0000", data1[2]);
    end
    checks++;
    if (data1[0] !== 16'hFFFF) begin
      errors++; $display("FAIL entry0_bypass got %h exp ffff", data1[0]);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (data1[2] !== 16'h0000 || pending1[2] !== 1'b0) begin
      errors++; $display("FAIL zero_reg_store got %h pend %b exp 0000 0", data1[2], pending1[2]);
    end
    checks++;
    if (data1[0] !== 16'hFFFF || pending1[0] !== 1'b1) begin
      errors++; $display("FAIL entry0_store got %h pend %b exp ffff 1", data1[0], pending1[0]);
    end
    @(negedge clock);
    write = 1'b1; writeAddress = 4'd9; writeData = 16'hAAAA;
    reserve = 1'b1; reserveAddress = 4'd9; address1 = 4'd9; address2 = 4'd1;
    #1;
    checks++;
    if (data1[0] !== 16'h0000 || data2[0] !== 16'h0000) begin
      errors++; $display("FAIL oor_bypass got %h/%h exp 0000", data1[0], data2[0]);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (data1[0] !== 16'h0000 || pending1[0] !== 1'b0 || data2[0] !== 16'h0000 || pending2[0] !== 1'b0) begin
      errors++; $display("FAIL oor_ignored got %h %b %h %b exp 0000 0 0000 0", data1[0], pending1[0], data2[0], pending2[0]);
    end
  endtask

  task automatic test_clear_sweep();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      write = 1'b1; writeAddress = 4'(i); writeData = 16'h1111;
      reserve = 1'b1; reserveAddress = 4'(i);
    end
    @(negedge clock);
    idle_inputs(); clear = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      idle_inputs();
      address1 = 4'(k);
      address2 = (k == 0) ? 4'd7 : 4'(k - 1);
      if (k == 2) begin
        write = 1'b1; writeAddress = 4'd6; writeData = 16'hDEAD; address2 = 4'd6;
      end
      if (k == 4) clear = 1'b1;
      #1;
      checks++;
      if (busy[0] !== 1'b1 || wready[0] !== 1'b0) begin
        errors++; $display("FAIL sweep_busy cyc%0d busy %b ready %b exp 1 0", k, busy[0], wready[0]);
      end
      checks++;
      if (data1[0] !== 16'h1111 || pending1[0] !== 1'b1) begin
        errors++; $display("FAIL sweep_ahead cyc%0d got %h pend %b exp 1111 1", k, data1[0], pending1[0]);
      end
      checks++;
      if (data2[0] !== ((k == 0 || k == 2) ? 16'h1111 : 16'h0000)) begin
        errors++; $display("FAIL sweep_behind cyc%0d got %h exp %h", k, data2[0],
                           (k == 0 || k == 2) ? 16'h1111 : 16'h0000);
      end
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (busy[0] !== 1'b0 || wready[0] !== 1'b1) begin
      errors++; $display("FAIL sweep_done busy %b ready %b exp 0 1", busy[0], wready[0]);
    end
    for (int i = 0; i < 8; i++) begin
      address1 = 4'(i);
      #1;
      checks++;
      if (data1[0] !== 16'h0000 || pending1[0] !== 1'b0) begin
        errors++; $display("FAIL post_sweep entry%0d got %h pend %b exp 0000 0", i, data1[0], pending1[0]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clock);
    write = 1'b1; writeAddress = 4'd7; writeData = 16'h2222;
    @(negedge clock);
    write = 1'b1; writeAddress = 4'd6; writeData = 16'h3333;
    reserve = 1'b1; reserveAddress = 4'd7;
    @(negedge clock);
    idle_inputs(); clear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      idle_inputs();
    end
    @(negedge clock);
    address1 = 4'd7; address2 = 4'd6;
    #1;
    checks++;
    if (data1[0] !== 16'h2222 || data2[0] !== 16'h3333 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL mid_sweep_pre got %h %h busy %b exp 2222 3333 1", data1[0], data2[0], busy[0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || wready[0] !== 1'b1) begin
      errors++; $display("FAIL mid_reset_ctrl busy %b ready %b exp 0 1", busy[0], wready[0]);
    end
    checks++;
    if (data1[0] !== 16'h0000 || data2[0] !== 16'h0000 || pending1[0] !== 1'b0) begin
      errors++; $display("FAIL mid_reset_data got %h %h pend %b exp 0000 0000 0", data1[0], data2[0], pending1[0]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    write = 1'b1; writeAddress = 4'd1; writeData = 16'h4444;
    #1;
    checks++;
    if (wready[0] !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready got %b exp 1", wready[0]);
    end
    @(negedge clock);
    idle_inputs(); address1 = 4'd1;
    #1;
    checks++;
    if (data1[0] !== 16'h4444 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL post_reset_write got %h busy %b exp 4444 0", data1[0], busy[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_zero_reg_range();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
